score_display: RTL

Display back-end for the 2048 game. It accepts a binary score from the game engine through a valid/ready handshake and converts it to eight BCD digits using a sequential double-dabble. It then multiplexes those digits onto the board's active-low 8-digit seven-segment display (`HEX`/`HEXAN`). It sits directly downstream of the game logic and drives the top-level `HEX` and `HEXAN` pins.

---
 rtl/display_pkg.sv | 54 +++++
 rtl/score_display_if.sv | 11 +
 rtl/bin2bcd_seq.sv | 74 +++++++
 rtl/score_display.sv | 91 +++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, segment decode and double-dabble helper for the score display.
package display_pkg;

    localparam int BCD_DIGITS = 8;
    localparam int BCD_W      = BCD_DIGITS * 4;
    localparam int unsigned SCORE_MAX = 99_999_999;

    // Segment codes {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before each shift
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Valid/ready score handshake between the game engine and the display back-end.
interface score_display_if #(
    parameter int VALUE_W = 27
);
    logic [VALUE_W-1:0] value_in;
    logic               value_valid;
    logic               value_ready;

    modport master (output value_in, output value_valid, input value_ready);
    modport slave  (input value_in, input value_valid, output value_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: captures a score, converts over VALUE_W cycles,
// then pulses load for one cycle with the BCD result stable.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VALUE_W = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid,
    output logic               value_ready,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd,
    output logic               load
);

    localparam int STEP_W = $clog2(VALUE_W + 1);

    conv_state_t        state, state_n;
    logic [VALUE_W-1:0] bin;
    logic [STEP_W-1:0]  step;
    logic [BCD_W-1:0]   adj;
    logic [63:0]        wide;
    logic [VALUE_W-1:0] sat;

    assign wide = 64'(value_in);
    assign sat  = (wide > 64'(SCORE_MAX)) ? VALUE_W'(SCORE_MAX) : value_in;
    assign adj  = dd_adjust(bcd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        value_ready = 1'b0;
        busy        = 1'b0;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                value_ready = 1'b1;
                if (value_valid) state_n = ST_CONV;
            end
            ST_CONV: begin
                busy = 1'b1;
                if (step == STEP_W'(VALUE_W - 1)) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                load    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            step <= '0;
        end else if (state == ST_IDLE && value_valid) begin
            bin  <= sat;
            bcd  <= '0;
            step <= '0;
        end else if (state == ST_CONV) begin
            {bcd, bin} <= {adj[BCD_W-2:0], bin, 1'b0};
            step       <= step + 1'b1;
        end
    end

endmodule

// File: rtl/score_display.sv
// Score display top: BCD conversion, display register, digit scan and segment decode.
// Optional LEADING_ZERO_BLANK_EN turns off anodes above the highest nonzero digit.
module score_display
    import display_pkg::*;
#(
    parameter int VALUE_W      = 27,
    parameter int DIGIT_CYCLES = 100_000
) (
    input  logic              clk,
    input  logic              rst,
    score_display_if.slave    bus,
    input  logic              blank,
    output logic              busy,
    output logic [6:0]        HEX,
    output logic [7:0]        HEXAN
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [BCD_W-1:0]      bcd;
    logic                  load;
    logic [BCD_W-1:0]      disp;
    logic [BCD_DIGITS-1:0] lz_off, lz_next;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            digit_idx;
    logic [3:0]            digit;

    bin2bcd_seq #(.VALUE_W(VALUE_W)) u_conv (
        .clk         (clk),
        .rst         (rst),
        .value_in    (bus.value_in),
        .value_valid (bus.value_valid),
        .value_ready (bus.value_ready),
        .busy        (busy),
        .bcd         (bcd),
        .load        (load)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; everything above the first nonzero is off
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_next = '0;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            seen       = seen | (bcd[i*4 +: 4] != 4'd0);
            lz_next[i] = ~seen;
        end
    end
`else
    assign lz_next = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp   <= '0;
            lz_off <= '0;
        end else if (load) begin
            disp   <= bcd;
            lz_off <= lz_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            digit_idx <= '0;
        end else if (cnt == CNT_W'(DIGIT_CYCLES - 1)) begin
            cnt       <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign digit = disp[digit_idx*4 +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HEX   <= SEG_OFF;
            HEXAN <= 8'hFF;
        end else if (blank) begin
            HEX   <= SEG_OFF;
            HEXAN <= 8'hFF;
        end else begin
            HEX   <= seg_decode(digit);
            HEXAN <= ~(8'd1 << digit_idx) | lz_off;
        end
    end

endmodule
